fifo_ctrl: RTL
==============

// Module: fifo_ctrl
// PURPOSE
//   Synchronous FIFO controller. Accepts push/pop requests and generates the write/read
//   enables and pointers for an internal RAM_memory instance. Produces registered
//   status flags: full, empty, almost_full, almost_empty, occupancy and error.
//   Sits directly in front of the RAM storage; together they form one FIFO queue
//   of the switch datapath.
// PARAMETERS
//   WORD_SIZE        4   data word width; drives RAM_memory MAIN_QUEUE_SIZE
//   ADDR_SIZE        3   pointer width; depth = 2**ADDR_SIZE (8); drives RAM_memory DATA_SIZE
//   ALMOST_FULL_TH   6   almost_full asserted when count >= this value
//   ALMOST_EMPTY_TH  2   almost_empty asserted when 0 < count <= this value
// PORTS
//   clk           in   1             single clock; all logic on posedge
//   reset         in   1             synchronous, active-high reset
//   push          in   1             write request; data_in is sampled this cycle
//   pop           in   1             read request
//   data_in       in   WORD_SIZE     word to enqueue
//   data_out      out  WORD_SIZE     dequeued word; valid when valid_out=1
//   valid_out     out  1             data_out carries the word popped in the previous cycle
//   full          out  1             count == 2**ADDR_SIZE
//   empty         out  1             count == 0
//   almost_full   out  1             count >= ALMOST_FULL_TH
//   almost_empty  out  1             count != 0 && count <= ALMOST_EMPTY_TH
//   count         out  ADDR_SIZE+1   current occupancy, 0..2**ADDR_SIZE
//   error         out  1             sticky; set on a rejected push or pop
// BEHAVIOUR
//   - Reset (sampled on posedge, reset=1): wr_ptr=rd_ptr=0, count=0, empty=1,
//     full=0, almost_full=0, almost_empty=0, error=0, valid_out=0, data_out=0.
//     The RAM instance sees reset_L = ~reset. RAM contents are not cleared.
//     Reset mid-operation discards all queued data; the cycle after reset deasserts,
//     the FIFO behaves as if it were empty.
//   - Acceptance, evaluated on the current-cycle state:
//       wr_en = push && (!full || pop)
//       rd_en = pop && !empty
//   - Full with push and pop in the same cycle: both are accepted and count holds.
//     The RAM reads the old word before the write lands.
//   - Empty with push and pop in the same cycle: only the push is accepted.
//     There is no fall-through, and error is set.
//   - Error: set when push && !wr_en, or when pop && !rd_en. It stays set until reset.
//     The state is unchanged by any rejected request.
//   - wr_en writes data_in to RAM[wr_ptr]; wr_ptr increments modulo 2**ADDR_SIZE.
//   - rd_en reads RAM[rd_ptr] into data_out (registered in the RAM);
//     rd_ptr increments modulo 2**ADDR_SIZE.
//   - Read latency is 1 cycle: valid_out <= rd_en, and data_out is valid together with it.
//     When valid_out=0, data_out holds its last value.
//   - count_next = count + wr_en - rd_en, computed at ADDR_SIZE+1 bits (no overflow by construction).
//   - All flags are registered and derived from count_next, so they are coherent with count
//     in the same cycle.
//   - Pointer wrap: pointers are plain ADDR_SIZE-bit counters that wrap from 7 to 0.
//     Full and empty are disambiguated by count only.
//   - Parameter legality: 0 < ALMOST_EMPTY_TH < ALMOST_FULL_TH <= 2**ADDR_SIZE.
//     An elaboration-time check flags violations.
// STRUCTURE
//   - One sub-module: the existing RAM_memory, instantiated once as u_ram.
//   - Pointer, count and flag logic lives in this module; there is no FSM beyond the
//     count register.
//   - The shared package (fifo_pkg) holds the default WORD_SIZE, ADDR_SIZE and thresholds,
//     and the localparam DEPTH = 2**ADDR_SIZE, so the queue stages agree.
// TESTING
//   1. Reset for 2 cycles -> empty=1, count=0, all other flags 0, valid_out=0, data_out=0.
//   2. Push 1..8 on consecutive cycles -> count 1..8; almost_full from count=6;
//      full at 8; error=0. Then pop 8 times -> data_out 1..8 one cycle after each pop;
//      empty at the end.
//   3. When full, push 9 with no pop -> error=1, count stays 8, pointers unchanged,
//      and a later pop returns 1.
//   4. When full, push A together with pop -> count stays 8; data_out=1 next cycle;
//      A is dequeued 8th.
//   5. When empty, push 5 together with pop -> count=1, valid_out=0, error=1;
//      a next-cycle pop returns 5.
//   6. Write 12 words with interleaved pops (pointer wrap), then assert reset mid-stream
//      -> all state returns to reset values; the next push/pop returns the new word.

Source files
------------

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared defaults for the switch queue stages: word width, pointer width,
//   almost-full / almost-empty thresholds and the derived queue depth. Every
//   stage imports this package so that all of them agree on the geometry.
//   Also provides a helper that validates a threshold set against a depth.
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_WORD_SIZE       = 4;
    localparam int FIFO_ADDR_SIZE       = 3;
    localparam int FIFO_ALMOST_FULL_TH  = 6;
    localparam int FIFO_ALMOST_EMPTY_TH = 2;
    localparam int FIFO_DEPTH           = 2 ** FIFO_ADDR_SIZE;

    // A legal threshold set satisfies 0 < almost_empty < almost_full <= depth.
    function automatic bit thresholds_ok(input int almost_empty_th,
                                         input int almost_full_th,
                                         input int depth);
        return (almost_empty_th > 0) &&
               (almost_empty_th < almost_full_th) &&
               (almost_full_th <= depth);
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_ctrl_ram.sv
// ---------------------------------------------------------------------------
// RAM_memory
//   Storage for one FIFO queue: 2**DATA_SIZE words of MAIN_QUEUE_SIZE bits,
//   one write port and one registered read port.
//   A write and a read of the same address in one cycle returns the old word.
// Ports
//   clk       in   clock, posedge
//   reset_L   in   synchronous active-low reset of the read register only
//   wr_en     in   write data_in to mem[wr_addr]
//   rd_en     in   load mem[rd_addr] into data_out
//   wr_addr   in   write address
//   rd_addr   in   read address
//   data_in   in   write word
//   data_out  out  registered read word, holds while rd_en=0
// ---------------------------------------------------------------------------
module RAM_memory #(
    parameter int MAIN_QUEUE_SIZE = 4,   // word width
    parameter int DATA_SIZE       = 3    // address width
) (
    input  logic                       clk,
    input  logic                       reset_L,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [DATA_SIZE-1:0]       wr_addr,
    input  logic [DATA_SIZE-1:0]       rd_addr,
    input  logic [MAIN_QUEUE_SIZE-1:0] data_in,
    output logic [MAIN_QUEUE_SIZE-1:0] data_out
);

    logic [MAIN_QUEUE_SIZE-1:0] mem_q [2**DATA_SIZE];
    logic [MAIN_QUEUE_SIZE-1:0] data_out_q;

    // NOTE: the storage array has no reset on purpose; clearing it would turn
    // the array into flops and nothing ever reads a word before it is written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    // NOTE: non-blocking assignments here mean a same-cycle read sees the word
    // stored before this edge, which is exactly the full push+pop behaviour.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            data_out_q <= '0;
        end else if (rd_en) begin
            data_out_q <= mem_q[rd_addr];
        end
    end

    assign data_out = data_out_q;

endmodule : RAM_memory

// File: rtl/fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ctrl
//   Synchronous FIFO controller in front of one RAM_memory instance. Accepts
//   push/pop requests, drives the RAM enables and pointers, and produces
//   registered status flags coherent with the registered occupancy.
// Ports
//   clk           in   clock, posedge
//   reset         in   synchronous active-high reset
//   push          in   write request, data_in sampled in the same cycle
//   pop           in   read request
//   data_in       in   word to enqueue
//   data_out      out  dequeued word, valid with valid_out
//   valid_out     out  data_out holds the word popped in the previous cycle
//   full          out  count == depth
//   empty         out  count == 0
//   almost_full   out  count >= ALMOST_FULL_TH
//   almost_empty  out  0 < count <= ALMOST_EMPTY_TH
//   count         out  occupancy, 0..depth
//   error         out  sticky, set by any rejected push or pop
// ---------------------------------------------------------------------------
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int WORD_SIZE       = FIFO_WORD_SIZE,
    parameter int ADDR_SIZE       = FIFO_ADDR_SIZE,
    parameter int ALMOST_FULL_TH  = FIFO_ALMOST_FULL_TH,
    parameter int ALMOST_EMPTY_TH = FIFO_ALMOST_EMPTY_TH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WORD_SIZE-1:0] data_in,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 error
);

    localparam int CNT_W = ADDR_SIZE + 1;
    localparam int DEPTH = 2 ** ADDR_SIZE;

    if (!thresholds_ok(ALMOST_EMPTY_TH, ALMOST_FULL_TH, DEPTH)) begin : g_bad_thresholds
        $error("fifo_ctrl: thresholds must satisfy 0 < ALMOST_EMPTY_TH < ALMOST_FULL_TH <= 2**ADDR_SIZE");
    end

    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 almost_full_q, almost_full_d;
    logic                 almost_empty_q, almost_empty_d;
    logic                 error_q, error_d;
    logic                 valid_q;
    logic                 wr_en, rd_en;

    // A pop frees a slot in the same cycle, so a full queue still takes a push
    // when it is paired with a pop. An empty queue never forwards a push.
    assign wr_en = push && (!full_q || pop);
    assign rd_en = pop && !empty_q;

    // NOTE: every variable gets a value on every path through this block, so
    // no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q + ADDR_SIZE'(wr_en);
        rd_ptr_d = rd_ptr_q + ADDR_SIZE'(rd_en);
        count_d  = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);

        // Flags come from the next count so they flip in the same cycle as count.
        full_d         = (count_d == CNT_W'(DEPTH));
        empty_d        = (count_d == '0);
        almost_full_d  = (count_d >= CNT_W'(ALMOST_FULL_TH));
        almost_empty_d = (count_d != '0) && (count_d <= CNT_W'(ALMOST_EMPTY_TH));

        error_d = error_q || (push && !wr_en) || (pop && !rd_en);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b0;
            error_q        <= 1'b0;
            valid_q        <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            error_q        <= error_d;
            valid_q        <= rd_en;
        end
    end

    RAM_memory #(
        .MAIN_QUEUE_SIZE (WORD_SIZE),
        .DATA_SIZE       (ADDR_SIZE)
    ) u_ram (
        .clk      (clk),
        .reset_L  (~reset),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .wr_addr  (wr_ptr_q),
        .rd_addr  (rd_ptr_q),
        .data_in  (data_in),
        .data_out (data_out)
    );

    assign valid_out    = valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign error        = error_q;

endmodule : fifo_ctrl
